// File: rtl/mux_xnor_sched_if.sv
// Request/response bundle for mux_xnor_sched.
// master: requesters + result consumer. slave: the scheduler.
interface mux_xnor_sched_if #(
    parameter int N_REQ = 4,
    parameter int W     = 4,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ*W-1:0] req_a;
    logic [N_REQ*W-1:0] req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [ID_W-1:0]    rsp_id;
    logic [W-1:0]       rsp_data;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/mux_xnor_sched.sv
// mux_xnor_sched: round-robin scheduler sharing one external 1-bit XNOR cell
// among N_REQ requesters. A granted operand pair is streamed LSB first through
// the cell and the collected result is returned with the requester id.
// Optional feature macro: MUX_SELFTEST_EN -- checks every cell output against
// the expected XNOR and raises a sticky err on mismatch. Without it err is 0.
// ID_W must equal max(1,$clog2(N_REQ)) and match the interface parameters.
module mux_xnor_sched #(
    parameter int N_REQ = 4,
    parameter int W     = 4,
    parameter int ID_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    mux_xnor_sched_if.slave   bus,
    output logic              mux_a,
    output logic              mux_b,
    input  logic              mux_out,
    output logic              busy,
    output logic              err
);
    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [W-1:0]      a_sh_q, a_sh_d;
    logic [W-1:0]      b_sh_q, b_sh_d;
    logic [W-1:0]      res_q, res_d;

    logic              gnt_any;
    logic [ID_W-1:0]   gnt_idx;
    logic [N_REQ-1:0]  gnt_oh;
    int                scan_idx;

    // Round-robin scan: first valid line after the last served one, wrapping.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        gnt_oh   = '0;
        scan_idx = 0;
        for (int off = 1; off <= N_REQ; off++) begin
            scan_idx = (int'(ptr_q) + off) % N_REQ;
            if (!gnt_any && bus.req_valid[scan_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = scan_idx[ID_W-1:0];
            end
        end
        gnt_oh[gnt_idx] = gnt_any;
    end

    // Next-state and datapath updates for IDLE -> SHIFT -> RESP -> IDLE.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    a_sh_d  = bus.req_a[int'(gnt_idx)*W +: W];
                    b_sh_d  = bus.req_b[int'(gnt_idx)*W +: W];
                    id_d    = gnt_idx;
                    ptr_d   = gnt_idx;
                    cnt_d   = '0;
                    // Clearing here keeps old results out of unprocessed bits.
                    res_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                res_d[cnt_q] = mux_out;
                a_sh_d       = a_sh_q >> 1;
                b_sh_d       = b_sh_q >> 1;
                cnt_d        = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(W-1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; ptr starts at N_REQ-1 so line 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= ID_W'(N_REQ-1);
            id_q    <= '0;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
        end
    end

    // Accept strobe is combinational and forced low while reset is asserted.
    assign bus.req_ready = (state_q == IDLE && !rst) ? gnt_oh : '0;
    assign mux_a         = (state_q == SHIFT) ? a_sh_q[0] : 1'b0;
    assign mux_b         = (state_q == SHIFT) ? b_sh_q[0] : 1'b0;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_id    = id_q;
    assign bus.rsp_data  = res_q;
    assign busy          = (state_q != IDLE);

`ifdef MUX_SELFTEST_EN
    logic err_q, err_d;

    // Sticky flag: any SHIFT cycle where the cell disagrees with a XNOR b.
    always_comb begin
        err_d = err_q;
        if (state_q == SHIFT && (mux_out != ~(mux_a ^ mux_b))) begin
            err_d = 1'b1;
        end
    end

    // Error register, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule
